// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
package fetch_pkg;

    typedef enum logic {
        FB_RUN   = 1'b0,
        FB_DRAIN = 1'b1
    } fb_state_e;

    localparam int unsigned FB_DEPTH_DEFAULT = 4;
    localparam int unsigned XLEN_DEFAULT     = 32;

    // Ring pointers carry one extra wrap bit above the index.
    function automatic int unsigned fb_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer_ring.sv
// Entry storage for the fetch buffer: PC written at allocation, instruction written on fill,
// and a filled bit per entry. One allocation port, one fill port, one read port.
module fetch_buffer_ring #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alloc_en_i,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
    input  logic [XLEN-1:0]          alloc_pc_i,
    input  logic                     fill_en_i,
    input  logic [$clog2(DEPTH)-1:0] fill_idx_i,
    input  logic [XLEN-1:0]          fill_inst_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [XLEN-1:0]          rd_inst_o,
    output logic                     rd_filled_o
);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  pc_d   [DEPTH];
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  inst_d [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] filled_d;

    // Allocation and fill never target the same slot: a fill only happens for an
    // entry that was allocated in an earlier cycle.
    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        filled_d = filled_q;
        if (alloc_en_i) begin
            pc_d[alloc_idx_i]     = alloc_pc_i;
            filled_d[alloc_idx_i] = 1'b0;
        end
        if (fill_en_i) begin
            inst_d[fill_idx_i]   = fill_inst_i;
            filled_d[fill_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filled_q <= '0;
        end else begin
            filled_q <= filled_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign rd_pc_o     = pc_q[rd_idx_i];
    assign rd_inst_o   = inst_q[rd_idx_i];
    assign rd_filled_o = filled_q[rd_idx_i];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order imem reads for the FetchUnit PC, pairs responses
// with their PC in a ring, and drains in-flight reads after a branch flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH_DEFAULT,
    parameter int unsigned XLEN  = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc,
    input  logic            io_flush,
    output logic            io_stall_en,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_pc,
    output logic [XLEN-1:0] io_out_inst
);

    localparam int unsigned   PW      = fb_ptr_width(DEPTH);
    localparam int unsigned   IW      = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    fb_state_e     state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] drop_q, drop_d;

    logic [PW-1:0] alloc;
    logic [PW-1:0] pending;
    logic [PW-1:0] outstanding;
    logic          req_fire;
    logic          resp_accept;
    logic          deq;
    logic          rd_filled;

    assign alloc            = tail_q - head_q;
    assign pending          = tail_q - fill_q;
    assign outstanding      = pending + drop_q;
    assign io_imem_req_addr = io_pc;

    always_comb begin
        state_d           = state_q;
        head_d            = head_q;
        fill_d            = fill_q;
        tail_d            = tail_q;
        drop_d            = drop_q;
        io_imem_req_valid = 1'b0;
        resp_accept       = 1'b0;

        if (!reset && state_q == FB_RUN && !io_flush) begin
            io_imem_req_valid = alloc < DEPTH_P;
        end
        req_fire     = io_imem_req_valid && io_imem_req_ready;
        // Stall is dropped in a flush cycle so the FetchUnit redirect takes effect.
        io_stall_en  = reset || (!req_fire && !io_flush);
        io_out_valid = !reset && (alloc != '0) && rd_filled;
        deq          = io_out_valid && io_out_ready;

        if (io_flush) begin
            head_d  = '0;
            fill_d  = '0;
            tail_d  = '0;
            // A same-cycle response belongs to the oldest outstanding read and is discarded.
            drop_d  = outstanding - PW'(io_imem_resp_valid && (outstanding != '0));
            state_d = (drop_d != '0) ? FB_DRAIN : FB_RUN;
        end else begin
            case (state_q)
                FB_RUN: begin
                    resp_accept = io_imem_resp_valid && (pending != '0);
                    if (req_fire)    tail_d = tail_q + ONE_P;
                    if (resp_accept) fill_d = fill_q + ONE_P;
                    if (deq)         head_d = head_q + ONE_P;
                end
                FB_DRAIN: begin
                    if (io_imem_resp_valid && (drop_q != '0)) drop_d = drop_q - ONE_P;
                    if (drop_d == '0) state_d = FB_RUN;
                end
                default: state_d = FB_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FB_RUN;
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            drop_q  <= drop_d;
        end
    end

    fetch_buffer_ring #(
        .DEPTH(DEPTH),
        .XLEN (XLEN)
    ) u_ring (
        .clk_i      (clock),
        .rst_i      (reset),
        .alloc_en_i (req_fire),
        .alloc_idx_i(tail_q[IW-1:0]),
        .alloc_pc_i (io_pc),
        .fill_en_i  (resp_accept),
        .fill_idx_i (fill_q[IW-1:0]),
        .fill_inst_i(io_imem_resp_data),
        .rd_idx_i   (head_q[IW-1:0]),
        .rd_pc_o    (io_out_pc),
        .rd_inst_o  (io_out_inst),
        .rd_filled_o(rd_filled)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a FetchUnit PC model and a fixed-latency in-order imem.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam logic [31:0] XOR_K = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_flush = 1'b0;
    logic        mem_ready = 1'b1;
    logic        out_ready = 1'b1;
    logic [31:0] br_target = 32'h0;
    int          mem_lat = 1;

    logic [31:0] fu_pc;
    logic        stall_en;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        pipe_v [8];
    logic [31:0] pipe_d [8];

    logic [31:0] fires_q [$];
    logic [31:0] outs_pc_q [$];
    logic [31:0] outs_inst_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    fetch_buffer dut (
        .clock             (clock),
        .reset             (reset),
        .io_pc             (fu_pc),
        .io_flush          (io_flush),
        .io_stall_en       (stall_en),
        .io_imem_req_valid (req_valid),
        .io_imem_req_ready (mem_ready),
        .io_imem_req_addr  (req_addr),
        .io_imem_resp_valid(resp_valid),
        .io_imem_resp_data (resp_data),
        .io_out_valid      (out_valid),
        .io_out_ready      (out_ready),
        .io_out_pc         (out_pc),
        .io_out_inst       (out_inst)
    );

    // FetchUnit: stall has priority over branch.
    always @(posedge clock) begin
        if (reset)          fu_pc <= 32'h0;
        else if (!stall_en) fu_pc <= io_flush ? br_target : fu_pc + 32'd4;
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) pipe_v[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                pipe_v[i] <= pipe_v[i+1];
                pipe_d[i] <= pipe_d[i+1];
            end
            pipe_v[7] <= 1'b0;
            if (req_valid && mem_ready) begin
                pipe_v[mem_lat-1] <= 1'b1;
                pipe_d[mem_lat-1] <= req_addr ^ XOR_K;
            end
        end
    end

    assign resp_valid = pipe_v[0];
    assign resp_data  = pipe_d[0];

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            if (req_valid && mem_ready) fires_q.push_back(req_addr);
            if (out_valid && out_ready) begin
                outs_pc_q.push_back(out_pc);
                outs_inst_q.push_back(out_inst);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Leaves the caller in C0, the first cycle with reset low and cleared state.
    task automatic reset_dut();
        cyc();
        reset    = 1'b1;
        io_flush = 1'b0;
        cyc();
        reset = 1'b0;
        fires_q.delete();
        outs_pc_q.delete();
        outs_inst_q.delete();
    endtask

    initial begin
        // Streaming, 1-cycle memory
        cyc();
        @(negedge clock);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_stall", 32'(stall_en), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(FB_RUN));
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("c0_req_valid", 32'(req_valid), 32'd1);
        check("c0_addr", req_addr, 32'h0);
        check("c0_stall", 32'(stall_en), 32'd0);
        cyc();
        @(negedge clock);
        check("c1_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            @(negedge clock);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, 32'(4 * k));
            check("stream_inst", out_inst, 32'(4 * k) ^ XOR_K);
        end

        // Backpressure until full
        out_ready = 1'b0;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            @(negedge clock);
            check("bp_req_valid", 32'(req_valid), 32'd1);
            check("bp_addr", req_addr, 32'(4 * k));
        end
        cyc();
        @(negedge clock);
        check("full_req_valid", 32'(req_valid), 32'd0);
        check("full_stall", 32'(stall_en), 32'd1);
        check("full_pc", fu_pc, 32'd16);
        check("full_out_pc", out_pc, 32'd0);
        cyc();
        @(negedge clock);
        check("full_pc_hold", fu_pc, 32'd16);
        cyc();
        out_ready = 1'b1;
        @(negedge clock);
        check("full_deq_no_issue", 32'(req_valid), 32'd0);
        check("full_fire_count", 32'(fires_q.size()), 32'd4);
        cyc();
        @(negedge clock);
        check("freed_issue", 32'(req_valid), 32'd1);
        check("freed_addr", req_addr, 32'd16);
        repeat (5) cyc();
        check("bp_out_count", 32'(outs_pc_q.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++) check("bp_out_order", outs_pc_q[k], 32'(4 * k));

        // Flush with three reads in flight, 3-cycle memory
        mem_lat   = 3;
        br_target = 32'h100;
        reset_dut();
        repeat (3) cyc();
        io_flush = 1'b1;
        @(negedge clock);
        check("fl3_stall", 32'(stall_en), 32'd0);
        check("fl3_req_valid", 32'(req_valid), 32'd0);
        cyc();
        io_flush = 1'b0;
        @(negedge clock);
        check("fl3_state", 32'(dut.state_q), 32'(FB_DRAIN));
        check("fl3_drop", 32'(dut.drop_q), 32'd2);
        check("fl3_drain_stall", 32'(stall_en), 32'd1);
        check("fl3_drain_out", 32'(out_valid), 32'd0);
        cyc();
        @(negedge clock);
        check("fl3_drop_dec", 32'(dut.drop_q), 32'd1);
        check("fl3_drain_req", 32'(req_valid), 32'd0);
        check("fl3_pc_hold", fu_pc, 32'h100);
        cyc();
        @(negedge clock);
        check("fl3_back_run", 32'(dut.state_q), 32'(FB_RUN));
        check("fl3_req_valid2", 32'(req_valid), 32'd1);
        check("fl3_redirect", req_addr, 32'h100);
        repeat (4) cyc();
        @(negedge clock);
        check("fl3_no_leak", 32'(outs_pc_q.size()), 32'd0);
        check("fl3_out_valid", 32'(out_valid), 32'd1);
        check("fl3_out_pc", out_pc, 32'h100);
        check("fl3_out_inst", out_inst, 32'h100 ^ XOR_K);

        // Flush coincident with the only pending response
        mem_lat   = 1;
        br_target = 32'h200;
        reset_dut();
        cyc();
        io_flush = 1'b1;
        @(negedge clock);
        check("fl1_stall", 32'(stall_en), 32'd0);
        cyc();
        io_flush = 1'b0;
        @(negedge clock);
        check("fl1_state", 32'(dut.state_q), 32'(FB_RUN));
        check("fl1_drop", 32'(dut.drop_q), 32'd0);
        check("fl1_req_valid", 32'(req_valid), 32'd1);
        check("fl1_addr", req_addr, 32'h200);
        check("fl1_out_valid", 32'(out_valid), 32'd0);
        repeat (2) cyc();
        @(negedge clock);
        check("fl1_out_pc", out_pc, 32'h200);
        check("fl1_out_inst", out_inst, 32'h200 ^ XOR_K);

        // Memory not ready for five cycles
        mem_ready = 1'b0;
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            @(negedge clock);
            check("nr_stall", 32'(stall_en), 32'd1);
            check("nr_pc", fu_pc, 32'h0);
        end
        cyc();
        mem_ready = 1'b1;
        @(negedge clock);
        check("nr_fire_stall", 32'(stall_en), 32'd0);
        cyc();
        @(negedge clock);
        check("nr_fire_count", 32'(fires_q.size()), 32'd1);
        check("nr_fire_addr", fires_q[0], 32'h0);
        check("nr_next_addr", req_addr, 32'd4);

        // Reset with entries buffered
        out_ready = 1'b0;
        reset_dut();
        repeat (2) cyc();
        @(negedge clock);
        check("mr_buffered", 32'(out_valid), 32'd1);
        cyc();
        reset = 1'b1;
        @(negedge clock);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_req_valid", 32'(req_valid), 32'd0);
        check("mr_stall", 32'(stall_en), 32'd1);
        cyc();
        @(negedge clock);
        check("mr_out_valid2", 32'(out_valid), 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("mr_req_after", 32'(req_valid), 32'd1);
        check("mr_addr_after", req_addr, 32'h0);
        check("mr_out_after", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between `FetchUnit` and decode. It takes the current PC from `FetchUnit`, issues in-order instruction-memory reads, pairs each returned word with its PC in a small ring buffer, and presents `{pc, inst}` to decode over a valid/ready handshake. It drives `FetchUnit.io_stall_en` to hold the PC whenever no request can issue, and it discards all buffered and in-flight fetches on a branch flush.

## Interface
- `DEPTH`, default 4: ring entries and maximum outstanding reads; power of two, at least 2.
- `XLEN`, default 32: PC and instruction width.
- Reset is synchronous and active-high.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `io_pc` in XLEN: current PC from `FetchUnit.io_pc`.
- `io_flush` in 1: branch redirect; driven together with `FetchUnit.io_br_en`.
- `io_stall_en` out 1: to `FetchUnit.io_stall_en`.
- `io_imem_req_valid` out 1: read request.
- `io_imem_req_ready` in 1: memory accepts the request.
- `io_imem_req_addr` out XLEN: equals `io_pc`.
- `io_imem_resp_valid` in 1: read data valid. Responses are in order, at least 1 cycle after acceptance.
- `io_imem_resp_data` in XLEN: instruction word.
- `io_out_valid` out 1: head entry filled.
- `io_out_ready` in 1: decode accepts.
- `io_out_pc` out XLEN: PC of the head entry.
- `io_out_inst` out XLEN: instruction of the head entry.

## Operation
- **Ring:** `DEPTH` entries of `{pc, inst, filled}`.
- **Pointers:** `head`, `fill` and `tail` are each log2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - `alloc = tail - head`, `pending = tail - fill`.
  - All pointer arithmetic wraps modulo 2·DEPTH.
- **States:** `RUN`, `DRAIN`.
- **RUN:**
  - `io_imem_req_valid = (alloc < DEPTH) & !io_flush`.
  - Fire (`req_valid & req_ready`): write `io_pc` at `tail`, clear `filled`, increment `tail`.
  - Response: write `inst` at `fill`, set `filled`, increment `fill`.
  - Dequeue (`out_valid & out_ready`): increment `head`.
  - Fire, response and dequeue can all occur in the same cycle.
- **Stall:** `io_stall_en = !(req fire) & !io_flush`.
  - In a flush cycle `io_stall_en` is forced low, because `FetchUnit` gives stall priority over branch and the redirect must land.
- **Flush (`io_flush` = 1, either state):**
  - `head`, `fill` and `tail` all become 0; `io_out_valid` goes low next cycle.
  - Nothing issues in the flush cycle.
  - `drop_cnt <= pending_now + drop_cnt - (resp_valid ? 1 : 0)`, where `pending_now` is taken before the flush. The same-cycle response is discarded and counted.
  - If the resulting `drop_cnt` is nonzero, go to `DRAIN`; otherwise stay in `RUN`.
- **DRAIN:**
  - No requests; `io_stall_en = 1` (unless `io_flush`).
  - Each response is discarded and decrements `drop_cnt`.
  - When `drop_cnt` reaches 0, return to `RUN`. The first request may issue in the following cycle.
- **Counter width:** `drop_cnt` is log2(DEPTH)+1 bits and never exceeds `DEPTH`.
- **Output registers:** `io_out_pc` and `io_out_inst` are read combinationally from `head`. Their values are don't-care while `io_out_valid` is 0.

## Timing
- **While `reset` is high:**
  - `io_imem_req_valid` = 0, `io_stall_en` = 1, `io_out_valid` = 0.
  - State = `RUN`; all pointers and `drop_cnt` = 0.
- **First request:** `io_imem_req_valid` = 1 in the first cycle after reset deasserts.
- **Latency:** a response in cycle N gives `io_out_valid` in cycle N+1, giving issue-to-decode latency of at least 2 cycles.
- **Throughput:** with 1-cycle memory and `io_out_ready` = 1, one instruction per cycle.
- **Full:** at `alloc == DEPTH`, `req_valid` = 0 and `io_stall_en` = 1. Dequeue and issue in the same cycle is not allowed; the freed slot issues the next cycle.
- **Combinational paths:** `io_stall_en` depends combinationally on `io_imem_req_ready` and `io_flush`. `io_imem_req_valid` does not depend on `req_ready`.
- **Reset mid-operation:** everything is cleared at once, and responses for earlier requests are not tracked. The memory is reset on the same reset.

## Structure
- **Package `fetch_pkg`:**
  - state enum `FB_RUN`, `FB_DRAIN`
  - `FB_DEPTH_DEFAULT` = 4
  - `XLEN_DEFAULT` = 32
  - pointer-width function `clog2(DEPTH)+1`
- **Sub-module `fetch_buffer_ring`:** entry storage plus the `filled` bits, with one write-alloc port, one fill port and one read port. The control logic, state machine and counters stay in `fetch_buffer`.

## Test plan
- **Streaming:** reset, then `io_pc` driven 0,4,8,… from a `FetchUnit` model; 1-cycle memory returning `inst = addr ^ 32'hA5A5_0000`; `out_ready` = 1.
  - Required: `io_out_*` yields `(0,0xA5A50000)`, `(4,0xA5A50004)`, … one per cycle from cycle 2.
- **Backpressure to full (DEPTH = 4):** `out_ready` = 0.
  - Required: exactly 4 requests (pc 0,4,8,12), then `io_stall_en` = 1 and PC holds at 16.
  - On releasing `out_ready`: PCs 0,4,8,12 leave in order, then 16 issues.
- **Flush with 3 pending (3-cycle memory):** assert `io_flush`.
  - Required: `io_stall_en` = 0 in that cycle and the FSM enters `DRAIN`.
  - The 3 late responses never reach `io_out_*`; the first request after drain uses the redirected PC.
- **Flush coincident with a response, `pending` = 1:**
  - Required: the response is dropped, `drop_cnt` = 0, the FSM stays in `RUN`, and a request issues next cycle.
- **Memory not ready:** `io_imem_req_ready` low for 5 cycles.
  - Required: `io_stall_en` = 1 and `io_pc` constant; the first fire is at the held PC.
- **Reset mid-stream:** assert `reset` with 2 entries buffered.
  - Required: `io_out_valid` = 0, `io_imem_req_valid` = 0 during reset; the request after reset is for PC 0.
